// File: rtl/fetch_unit.sv
// Single-outstanding fetch/load-store port between the core pipeline and the system bus.
// Each of the 4 threads keeps a 1-entry read buffer; writes update any matching buffer in place.
module fetch_unit #(
  parameter logic [31:0] IDLE_WORD = 32'h0000_0001,
  parameter int          TIMEOUT   = 16,
  parameter bit          BUF_EN    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_enable,
  input  logic        write_mode,
  input  logic [31:0] addr,
  input  logic [31:0] data_i,
  input  logic [1:0]  thread,
  output logic [31:0] data_o,
  output logic        ack,
  input  logic        W_CLK,
  input  logic        W_ACK,
  input  logic [31:0] W_DATA_I,
  output logic [31:0] W_DATA_O,
  output logic [31:0] W_ADDR,
  output logic        W_WRITE
);
  localparam int NT = 4;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_HIT, S_BUS, S_DONE} state_t;

  state_t           r_state;
  logic [31:0]      r_req_addr, r_req_data;
  logic             r_req_write;
  logic [1:0]       r_req_thread;
  logic [CW-1:0]    r_cnt;
  logic [31:0]      r_data_o, r_w_addr, r_w_data;
  logic             r_ack, r_w_write;
  logic [NT-1:0]    r_vld;
  logic [31:0]      r_tag [NT];
  logic [31:0]      r_dat [NT];

  logic             w_hit;
  logic             w_unused_wclk;

  // W_CLK is the same clock as clk; kept only as a port
  assign w_unused_wclk = W_CLK;

  // Hit is decided on the live request so data_o/ack can update on the accept edge
  assign w_hit = BUF_EN && !write_mode && r_vld[thread] && (r_tag[thread] == addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_req_addr   <= '0;
      r_req_data   <= '0;
      r_req_write  <= 1'b0;
      r_req_thread <= '0;
      r_cnt        <= '0;
      r_data_o     <= IDLE_WORD;
      r_ack        <= 1'b0;
      r_w_addr     <= '0;
      r_w_data     <= '0;
      r_w_write    <= 1'b0;
      r_vld        <= '0;
      for (int i = 0; i < NT; i++) begin
        r_tag[i] <= '0;
        r_dat[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ack <= 1'b0;
          if (f_enable) begin
            r_req_addr   <= addr;
            r_req_data   <= data_i;
            r_req_write  <= write_mode;
            r_req_thread <= thread;
            if (w_hit) begin
              r_state  <= S_HIT;
              r_data_o <= r_dat[thread];
              r_ack    <= 1'b1;
            end else begin
              r_state   <= S_BUS;
              r_w_addr  <= addr;
              r_w_data  <= data_i;
              r_w_write <= write_mode;
            end
          end
        end
        S_HIT: begin
          r_ack   <= 1'b0;
          r_state <= S_IDLE;
        end
        S_BUS: begin
          if (W_ACK) begin
            r_state   <= S_DONE;
            r_ack     <= 1'b1;
            r_w_write <= 1'b0;
            r_cnt     <= '0;
            if (!r_req_write) begin
              r_data_o <= W_DATA_I;
              if (BUF_EN) begin
                r_vld[r_req_thread] <= 1'b1;
                r_tag[r_req_thread] <= r_req_addr;
                r_dat[r_req_thread] <= W_DATA_I;
              end
            end else begin
              for (int i = 0; i < NT; i++)
                if (r_vld[i] && (r_tag[i] == r_req_addr))
                  r_dat[i] <= r_req_data;
            end
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            // Slave never answered: complete with the idle word, leave buffers alone
            r_state   <= S_DONE;
            r_ack     <= 1'b1;
            r_w_write <= 1'b0;
            r_cnt     <= '0;
            r_data_o  <= IDLE_WORD;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_ack   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign data_o   = r_data_o;
  assign ack      = r_ack;
  assign W_ADDR   = r_w_addr;
  assign W_DATA_O = r_w_data;
  assign W_WRITE  = r_w_write;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed + randomized bench for fetch_unit, checked against a per-thread buffer model.
module tb_fetch_unit;
  localparam logic [31:0] IDLE_WORD = 32'h0000_0001;
  localparam int          TIMEOUT   = 16;
  localparam bit          BUF_EN    = 1'b1;
  localparam int          NEVER     = 99;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_enable, write_mode;
  logic [31:0] addr, data_i;
  logic [1:0]  thread;
  logic [31:0] data_o;
  logic        ack;
  logic        W_ACK;
  logic [31:0] W_DATA_I, W_DATA_O, W_ADDR;
  logic        W_WRITE;

  int checks = 0;
  int failures = 0;

  // Reference: what each thread's buffer holds, and the last completed data_o
  bit          mv   [4];
  logic [31:0] mtag [4];
  logic [31:0] mdat [4];
  logic [31:0] mdo;

  fetch_unit #(.IDLE_WORD(IDLE_WORD), .TIMEOUT(TIMEOUT), .BUF_EN(BUF_EN)) dut (
    .clk(clk), .rst(rst), .f_enable(f_enable), .write_mode(write_mode),
    .addr(addr), .data_i(data_i), .thread(thread), .data_o(data_o), .ack(ack),
    .W_CLK(clk), .W_ACK(W_ACK), .W_DATA_I(W_DATA_I), .W_DATA_O(W_DATA_O),
    .W_ADDR(W_ADDR), .W_WRITE(W_WRITE)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mv[i] = 1'b0; mtag[i] = '0; mdat[i] = '0;
    end
    mdo = IDLE_WORD;
  endtask

  // d = number of BUS cycles the slave waits before raising W_ACK (>= TIMEOUT means never)
  task automatic do_req(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] t, input int d, input logic [31:0] rd);
    logic [31:0] prev_waddr, exp_do;
    int cyc, exp_lat;
    bit hit, tmo;
    hit = BUF_EN && !wr && mv[t] && (mtag[t] == a);
    tmo = !hit && (d >= TIMEOUT);
    exp_lat = hit ? 1 : (tmo ? TIMEOUT + 1 : d + 2);
    @(negedge clk);
    f_enable = 1'b1; write_mode = wr; addr = a; data_i = wd; thread = t;
    W_DATA_I = rd; W_ACK = (d == 0);
    prev_waddr = W_ADDR;
    @(posedge clk); #1;
    f_enable = 1'b0; addr = $urandom; data_i = $urandom;
    write_mode = 1'($urandom); thread = 2'($urandom);
    cyc = 1;
    if (!hit) begin
      chk("bus_addr", W_ADDR, a);
      chk("bus_write", 32'(W_WRITE), 32'(wr));
      if (wr) chk("bus_wdata", W_DATA_O, wd);
    end
    while (ack !== 1'b1 && cyc < 60) begin
      W_ACK = (d < TIMEOUT) && (cyc >= d + 1);
      @(posedge clk); #1;
      cyc++;
    end
    W_ACK = 1'b0;
    exp_do = hit ? mdat[t] : (tmo ? IDLE_WORD : (wr ? mdo : rd));
    chk("ack_latency", 32'(cyc), 32'(exp_lat));
    chk("data_o", data_o, exp_do);
    chk("wwrite_in_done", 32'(W_WRITE), 32'd0);
    if (hit) chk("hit_no_bus", W_ADDR, prev_waddr);
    @(posedge clk); #1;
    chk("ack_single_pulse", 32'(ack), 32'd0);
    mdo = exp_do;
    if (!hit && !tmo) begin
      if (!wr) begin
        if (BUF_EN) begin mv[t] = 1'b1; mtag[t] = a; mdat[t] = rd; end
      end else begin
        for (int i = 0; i < 4; i++)
          if (mv[i] && mtag[i] == a) mdat[i] = wd;
      end
    end
  endtask

  initial begin
    rst = 1'b1; f_enable = 1'b0; write_mode = 1'b0; addr = '0; data_i = '0;
    thread = '0; W_ACK = 1'b0; W_DATA_I = '0;
    model_reset();
    #12 rst = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_data_o", data_o, IDLE_WORD);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_wwrite", 32'(W_WRITE), 32'd0);
    chk("rst_waddr", W_ADDR, 32'd0);
    chk("rst_wdata", W_DATA_O, 32'd0);

    // f_enable unknown in IDLE must not start anything
    f_enable = 1'bx; W_ACK = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("x_en_ack", 32'(ack), 32'd0);
    chk("x_en_data_o", data_o, IDLE_WORD);
    f_enable = 1'b0; W_ACK = 1'b0;

    do_req(1'b0, 32'h100, 32'h0, 2'd0, 0, 32'hCAFE_0001);       // miss, immediate slave ack
    do_req(1'b0, 32'h100, 32'h0, 2'd0, 0, 32'hDEAD_BEEF);       // hit, bus untouched
    do_req(1'b0, 32'h100, 32'h0, 2'd1, 2, 32'h1111_2222);       // other thread misses
    do_req(1'b1, 32'h100, 32'h1234_5678, 2'd2, 1, 32'h0);       // write updates t0/t1 copies
    do_req(1'b0, 32'h100, 32'h0, 2'd0, 0, 32'hBAD0_BAD0);       // hit with written data
    do_req(1'b0, 32'h500, 32'h0, 2'd3, NEVER, 32'h5555_5555);   // timeout
    do_req(1'b0, 32'h500, 32'h0, 2'd3, 0, 32'h5000_0005);       // not filled by timeout
    do_req(1'b0, 32'h600, 32'h0, 2'd3, TIMEOUT - 1, 32'h6000_0006); // latest possible ack

    // Reset in the middle of a bus write
    @(negedge clk);
    f_enable = 1'b1; write_mode = 1'b1; addr = 32'h700; data_i = 32'h7777_7777;
    thread = 2'd2; W_ACK = 1'b0;
    @(posedge clk); #1; f_enable = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("mid_bus_wwrite", 32'(W_WRITE), 32'd1);
    #2 rst = 1'b1; #1;
    chk("abort_wwrite", 32'(W_WRITE), 32'd0);
    chk("abort_ack", 32'(ack), 32'd0);
    chk("abort_data_o", data_o, IDLE_WORD);
    @(negedge clk); rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    chk("abort_no_ack", 32'(ack), 32'd0);
    do_req(1'b0, 32'h100, 32'h0, 2'd0, 0, 32'h0A0A_0A0A);       // buffers were invalidated

    for (int n = 0; n < 80; n++) begin
      int r;
      logic [31:0] a;
      r = int'($urandom_range(0, 19));
      a = 32'h100 + 32'($urandom_range(0, 3)) * 32'h4;
      do_req(($urandom_range(0, 9) < 3), a, $urandom, 2'($urandom),
             (r == 19) ? NEVER : (r % 4), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
